// File: rtl/psum_acc_drain.sv
// psum_acc_drain
//
// Sits after the corelet output FIFO. Pops per-tap partial-sum rows and
// folds them into a psum buffer indexed by output position (nij), summing
// over all kernel taps (kij). Once the last tap is in, the finished rows go
// out in order 0..nij-1 on a valid/ready port, with optional per-lane ReLU.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        one-cycle pulse, starts a tile (IDLE only)
//   relu_en      captured with an accepted start; 1 = clamp negative lanes
//   ofifo_out    FIFO head row (first-word-fall-through)
//   ofifo_valid  FIFO head row valid
//   ofifo_rd     pop FIFO head this cycle (combinational, ACC only)
//   out_data     finished row, col lanes of psum_bw signed bits
//   out_valid    out_data valid
//   out_ready    downstream accepts out_data
//   busy         high in every state except IDLE
//   done         one-cycle pulse after the tile's last row is accepted
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// ACC   | popping FIFO rows and accumulating into psum_buf
// LOAD  | registering row 0 of the finished buffer onto out_data
// OUT   | streaming rows out; next row reloads on the same edge as a transfer
// DONE  | done pulse, back to IDLE
module psum_acc_drain #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int nij     = 16,
    parameter int kij     = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     relu_en,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    input  logic                     ofifo_valid,
    output logic                     ofifo_rd,
    output logic [col*psum_bw-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int ROW_W = col * psum_bw;
    localparam int NIJ_W = (nij > 1) ? $clog2(nij) : 1;
    localparam int KIJ_W = (kij > 1) ? $clog2(kij) : 1;

    localparam logic [NIJ_W-1:0] NIJ_LAST = NIJ_W'(nij - 1);
    localparam logic [KIJ_W-1:0] KIJ_LAST = KIJ_W'(kij - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        LOAD,
        OUT,
        DONE
    } state_t;

    state_t             state;
    logic [NIJ_W-1:0]   nij_cnt;
    logic [KIJ_W-1:0]   kij_cnt;
    logic [NIJ_W-1:0]   out_cnt;
    logic [NIJ_W-1:0]   out_cnt_nxt;
    logic               relu_q;
    logic               xfer;

    // Accumulation storage; contents are meaningless until tap 0 of a tile
    // has overwritten them, so no reset is needed.
    logic [ROW_W-1:0]   psum_buf [nij];

    // Per-lane wrapping add; carries must not cross lane boundaries.
    function automatic logic [ROW_W-1:0] lane_add(input logic [ROW_W-1:0] a,
                                                  input logic [ROW_W-1:0] b);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int l = 0; l < col; l++) begin
            r[l*psum_bw +: psum_bw] = a[l*psum_bw +: psum_bw] + b[l*psum_bw +: psum_bw];
        end
        return r;
    endfunction

    // Per-lane ReLU: a lane with its sign bit set becomes 0, zero passes.
    function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] r_in,
                                                  input logic             en);
        logic [ROW_W-1:0] r;
        r = r_in;
        for (int l = 0; l < col; l++) begin
            if (en && r_in[l*psum_bw + psum_bw - 1]) begin
                r[l*psum_bw +: psum_bw] = '0;
            end
        end
        return r;
    endfunction

    assign ofifo_rd    = (state == ACC) && ofifo_valid;
    assign xfer        = out_valid && out_ready;
    assign out_cnt_nxt = out_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (ofifo_rd) begin
            if (kij_cnt == '0) begin
                psum_buf[nij_cnt] <= ofifo_out;
            end else begin
                psum_buf[nij_cnt] <= lane_add(psum_buf[nij_cnt], ofifo_out);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            nij_cnt   <= '0;
            kij_cnt   <= '0;
            out_cnt   <= '0;
            relu_q    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ACC;
                        nij_cnt <= '0;
                        kij_cnt <= '0;
                        out_cnt <= '0;
                        relu_q  <= relu_en;
                        busy    <= 1'b1;
                    end
                end

                ACC: begin
                    if (ofifo_valid) begin
                        if (nij_cnt == NIJ_LAST) begin
                            nij_cnt <= '0;
                            if (kij_cnt == KIJ_LAST) begin
                                kij_cnt <= '0;
                                state   <= LOAD;
                            end else begin
                                kij_cnt <= kij_cnt + 1'b1;
                            end
                        end else begin
                            nij_cnt <= nij_cnt + 1'b1;
                        end
                    end
                end

                LOAD: begin
                    out_data  <= relu_row(psum_buf[out_cnt], relu_q);
                    out_valid <= 1'b1;
                    state     <= OUT;
                end

                OUT: begin
                    if (xfer) begin
                        if (out_cnt == NIJ_LAST) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            // Reload on the transfer edge so a held-high
                            // out_ready drains one row per cycle.
                            out_cnt  <= out_cnt_nxt;
                            out_data <= relu_row(psum_buf[out_cnt_nxt], relu_q);
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
